// File: rtl/product_bcd_display_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : product_bcd_display_if                                       |
// | Brief   : Conversion handshake between product source and BCD display  |
// | Rev     : 1.0                                                          |
// +------------------------------------------------------------------------+
interface product_bcd_display_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] product;
  logic         busy;
  logic         bcd_valid;
  logic         sign;
  logic [19:0]  bcd;

  modport master (
    output start, product,
    input  busy, bcd_valid, sign, bcd
  );

  modport slave (
    input  start, product,
    output busy, bcd_valid, sign, bcd
  );
endinterface
`default_nettype wire

// File: rtl/product_bcd_display.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : product_bcd_display                                          |
// | Brief   : Signed product to 5-digit BCD with 6-digit 7-segment scan    |
// | Rev     : 1.0                                                          |
// +------------------------------------------------------------------------+
module product_bcd_display #(
  parameter int W           = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  product_bcd_display_if.slave  bus,
  output logic [6:0]            seg,
  output logic [5:0]            an
);

  localparam int              DIV_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [4:0]      c_ITER     = 5'(W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_mag;
  logic [19:0]  r_bcd_sr;
  logic [4:0]   r_cnt;
  logic         r_sign_sr;
  logic         r_busy;
  logic         r_valid;
  logic         r_sign;
  logic [19:0]  r_bcd;
  logic [19:0]  w_adj;

  // Add-3 correction applied to every nibble before each shift
  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_bcd_sr[4*gi +: 4] >= 4'd5) ?
                              (r_bcd_sr[4*gi +: 4] + 4'd3) : r_bcd_sr[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_mag     <= '0;
      r_bcd_sr  <= '0;
      r_cnt     <= '0;
      r_sign_sr <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_sign    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sign_sr <= bus.product[W-1];
            r_mag     <= bus.product[W-1] ? (~bus.product + W'(1)) : bus.product;
            r_bcd_sr  <= '0;
            r_cnt     <= c_ITER;
            r_busy    <= 1'b1;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd_sr, r_mag} <= {w_adj, r_mag} << 1;
          r_cnt             <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_bcd   <= r_bcd_sr;
          r_sign  <= r_sign_sr;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.bcd_valid = r_valid;
  assign bus.sign      = r_sign;
  assign bus.bcd       = r_bcd;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_idx <= 3'd0;
    end else if (r_div == c_DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  // w_zN: digit N and every digit above it are zero, so digit N is blanked
  logic w_z4, w_z3, w_z2, w_z1;
  assign w_z4 = (r_bcd[19:16] == 4'd0);
  assign w_z3 = w_z4 && (r_bcd[15:12] == 4'd0);
  assign w_z2 = w_z3 && (r_bcd[11:8]  == 4'd0);
  assign w_z1 = w_z2 && (r_bcd[7:4]   == 4'd0);

  always_comb begin
    seg = 7'h7F;
    an  = ~(6'd1 << r_idx);
    case (r_idx)
      3'd0:    seg = seg_of(r_bcd[3:0]);
      3'd1:    seg = w_z1 ? 7'h7F : seg_of(r_bcd[7:4]);
      3'd2:    seg = w_z2 ? 7'h7F : seg_of(r_bcd[11:8]);
      3'd3:    seg = w_z3 ? 7'h7F : seg_of(r_bcd[15:12]);
      3'd4:    seg = w_z4 ? 7'h7F : seg_of(r_bcd[19:16]);
      3'd5:    seg = r_sign ? 7'h3F : 7'h7F;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_display.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_product_bcd_display                                       |
// | Brief   : Directed self-checking bench for product_bcd_display         |
// | Rev     : 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_product_bcd_display;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [5:0] an;
  int         total;
  int         bad;

  product_bcd_display_if #(.W(16)) bus ();

  product_bcd_display #(.W(16), .REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .seg (seg),
    .an  (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_convert(input logic [15:0] p);
    bit seen;
    seen = 1'b0;
    bus.start   = 1'b1;
    bus.product = p;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.bcd_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL convert_timeout product=%h got no bcd_valid, expected one", p);
    end
  endtask

  task automatic wait_digit(input int idx, output bit found);
    logic [5:0] tgt;
    tgt   = ~(6'd1 << idx);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (an === tgt) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start   = 1'b0;
    bus.product = 16'h0000;
    #12;
    total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.bcd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.bcd_valid); end
    total++; if (bus.bcd !== 20'h0)      begin bad++; $display("FAIL reset_bcd got=%h exp=0", bus.bcd); end
    total++; if (bus.sign !== 1'b0)      begin bad++; $display("FAIL reset_sign got=%b exp=0", bus.sign); end
    total++; if (an !== 6'b111110)       begin bad++; $display("FAIL reset_an got=%b exp=111110", an); end
    total++; if (seg !== 7'h40)          begin bad++; $display("FAIL reset_seg got=%h exp=40", seg); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called right after reset release: after j rising edges the index is (j/4)%6
  task automatic test_scan();
    logic [5:0] ea;
    logic [6:0] es;
    int         idx;
    for (int j = 0; j < 26; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      idx = (j / 4) % 6;
      ea  = ~(6'd1 << idx);
      es  = (idx == 0) ? 7'h40 : 7'h7F;
      total++; if (an !== ea)  begin bad++; $display("FAIL scan_an j=%0d got=%b exp=%b", j, an, ea); end
      total++; if (seg !== es) begin bad++; $display("FAIL scan_seg j=%0d got=%h exp=%h", j, seg, es); end
    end
  endtask

  task automatic test_conversion();
    logic [15:0] p  [6];
    logic [19:0] eb [6];
    logic        esg[6];
    p[0] = 16'h3039; eb[0] = 20'h12345; esg[0] = 1'b0;
    p[1] = 16'hC000; eb[1] = 20'h16384; esg[1] = 1'b1;
    p[2] = 16'h8000; eb[2] = 20'h32768; esg[2] = 1'b1;
    p[3] = 16'h0007; eb[3] = 20'h00007; esg[3] = 1'b0;
    p[4] = 16'h0000; eb[4] = 20'h00000; esg[4] = 1'b0;
    p[5] = 16'h7FFF; eb[5] = 20'h32767; esg[5] = 1'b0;
    for (int v = 0; v < 6; v++) begin
      bus.start   = 1'b1;
      bus.product = p[v];
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.product = 16'hAAAA;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL conv_busy_k v=%0d got=%b exp=1", v, bus.busy); end
      for (int i = 1; i <= 16; i++) begin
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b1 || bus.bcd_valid !== 1'b0) begin
          bad++;
          $display("FAIL conv_window v=%0d edge=k+%0d busy=%b valid=%b exp busy=1 valid=0", v, i, bus.busy, bus.bcd_valid);
        end
      end
      @(posedge clk); #1;
      total++; if (bus.bcd_valid !== 1'b1) begin bad++; $display("FAIL conv_valid v=%0d got=%b exp=1", v, bus.bcd_valid); end
      total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL conv_busy_end v=%0d got=%b exp=0", v, bus.busy); end
      total++; if (bus.bcd !== eb[v])      begin bad++; $display("FAIL conv_bcd v=%0d got=%h exp=%h", v, bus.bcd, eb[v]); end
      total++; if (bus.sign !== esg[v])    begin bad++; $display("FAIL conv_sign v=%0d got=%b exp=%b", v, bus.sign, esg[v]); end
      @(posedge clk); #1;
      total++; if (bus.bcd_valid !== 1'b0) begin bad++; $display("FAIL conv_pulse v=%0d got=%b exp=0", v, bus.bcd_valid); end
    end
  endtask

  task automatic test_display();
    logic [15:0] p [12];
    int          di[12];
    logic [6:0]  es[12];
    bit          found;
    p[0]  = 16'h3039; di[0]  = 4; es[0]  = 7'h79;
    p[1]  = 16'h3039; di[1]  = 0; es[1]  = 7'h12;
    p[2]  = 16'hC000; di[2]  = 5; es[2]  = 7'h3F;
    p[3]  = 16'hC000; di[3]  = 3; es[3]  = 7'h02;
    p[4]  = 16'h0007; di[4]  = 0; es[4]  = 7'h78;
    p[5]  = 16'h0007; di[5]  = 1; es[5]  = 7'h7F;
    p[6]  = 16'h0007; di[6]  = 4; es[6]  = 7'h7F;
    p[7]  = 16'h0007; di[7]  = 5; es[7]  = 7'h7F;
    p[8]  = 16'hFFF6; di[8]  = 1; es[8]  = 7'h79;
    p[9]  = 16'hFFF6; di[9]  = 2; es[9]  = 7'h7F;
    p[10] = 16'h8000; di[10] = 2; es[10] = 7'h78;
    p[11] = 16'h0000; di[11] = 0; es[11] = 7'h40;
    for (int v = 0; v < 12; v++) begin
      do_convert(p[v]);
      wait_digit(di[v], found);
      total++;
      if (!found || seg !== es[v]) begin
        bad++;
        $display("FAIL disp_seg product=%h digit=%0d found=%b got=%h exp=%h", p[v], di[v], found, seg, es[v]);
      end
    end
  endtask

  task automatic test_ignore();
    int nvalid;
    nvalid = 0;
    bus.start   = 1'b1;
    bus.product = 16'h0064;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      if (j == 4)  begin bus.start = 1'b1; bus.product = 16'h0001; end
      if (j == 5)  bus.start = 1'b0;
      if (j == 16) begin bus.start = 1'b1; bus.product = 16'hFFFF; end
      if (j == 17) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.bcd_valid === 1'b1) nvalid++;
      if (j == 17) begin
        total++; if (bus.bcd_valid !== 1'b1) begin bad++; $display("FAIL ign_valid_time got=%b exp=1", bus.bcd_valid); end
      end
      if (j == 18) begin
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_update_start busy=%b exp=0", bus.busy); end
      end
    end
    total++; if (nvalid != 1)          begin bad++; $display("FAIL ign_pulses got=%0d exp=1", nvalid); end
    total++; if (bus.bcd !== 20'h00100) begin bad++; $display("FAIL ign_bcd got=%h exp=00100", bus.bcd); end
    total++; if (bus.sign !== 1'b0)     begin bad++; $display("FAIL ign_sign got=%b exp=0", bus.sign); end
  endtask

  task automatic test_back_to_back();
    bus.start   = 1'b1;
    bus.product = 16'h0007;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    total++; if (bus.bcd_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b exp=1", bus.bcd_valid); end
    bus.start   = 1'b1;
    bus.product = 16'hFFF6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b exp=1", bus.busy); end
    repeat (17) begin @(posedge clk); #1; end
    total++; if (bus.bcd_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b exp=1", bus.bcd_valid); end
    total++; if (bus.bcd !== 20'h00010)  begin bad++; $display("FAIL b2b_bcd got=%h exp=00010", bus.bcd); end
    total++; if (bus.sign !== 1'b1)      begin bad++; $display("FAIL b2b_sign got=%b exp=1", bus.sign); end
  endtask

  task automatic test_reset_mid_conv();
    int nvalid;
    bus.start   = 1'b1;
    bus.product = 16'h3039;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    total++; if (bus.bcd !== 20'h0)      begin bad++; $display("FAIL rmid_bcd got=%h exp=0", bus.bcd); end
    total++; if (bus.sign !== 1'b0)      begin bad++; $display("FAIL rmid_sign got=%b exp=0", bus.sign); end
    total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.bcd_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.bcd_valid); end
    total++; if (an !== 6'b111110)       begin bad++; $display("FAIL rmid_an got=%b exp=111110", an); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (bus.bcd_valid === 1'b1 || bus.busy === 1'b1) nvalid++;
    end
    total++; if (nvalid != 0) begin bad++; $display("FAIL rmid_no_valid got=%0d active cycles exp=0", nvalid); end
    do_convert(16'hFFFF);
    total++; if (bus.bcd !== 20'h00001) begin bad++; $display("FAIL rmid_after_bcd got=%h exp=00001", bus.bcd); end
    total++; if (bus.sign !== 1'b1)     begin bad++; $display("FAIL rmid_after_sign got=%b exp=1", bus.sign); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_scan();
    test_conversion();
    test_display();
    test_ignore();
    test_back_to_back();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/product_bcd_display.md
Name: product_bcd_display

Overview:
Downstream consumer of the Booth multiplier's 16-bit two's-complement product.
- Captures the product on a start pulse, typically wired to the multiplier's done.
- Converts sign-magnitude to 5 BCD digits with a sequential double-dabble (one shift per clock).
- Drives a 6-digit multiplexed common-anode 7-segment display: sign digit plus 5 magnitude digits.
- Holds the last converted value on the display until the next accepted start.

Parameters:
W, 16, product width (design supports only 16; 5 BCD digits cover magnitudes up to 32768)
REFRESH_DIV, 50000, clock cycles each display digit stays lit before the scan advances (must be >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to convert product
product  input  16  signed two's-complement value, sampled on the accepted start edge
busy  output  1  high while a conversion is in progress
bcd_valid  output  1  one-cycle pulse when bcd and sign are updated
sign  output  1  1 = displayed value negative
bcd  output  20  five BCD digits; [3:0] = units, [19:16] = ten-thousands
seg  output  7  active-low segments {g,f,e,d,c,b,a}
an  output  6  active-low one-hot digit enable; an[0] = units, an[5] = sign digit

Behaviour:
Reset (rst=0, asynchronous):
- FSM to IDLE; busy=0, bcd_valid=0, sign=0, bcd=0.
- Scan index=0, divider=0, an=6'b111110, seg=7'h40 (shows "0").
- Reset during CONV aborts the conversion; no bcd_valid follows.

FSM states: IDLE, CONV, UPDATE.
- IDLE: start=1 at edge k is accepted.
  - Latch sign_r = product[15] and mag = product[15] ? (~product + 1) : product, 16-bit unsigned (0x8000 gives 32768).
  - Clear 20-bit BCD shift register; iteration counter = 16; go to CONV; busy=1 from edge k.
- CONV: each edge, every BCD nibble >= 5 gets +3; then {bcd_sr, mag} shifts left by 1 and the counter decrements.
  - After the 16th shift (edge k+16), go to UPDATE.
- UPDATE (edge k+17): bcd <= bcd_sr, sign <= sign_r, bcd_valid=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: acceptance edge to bcd_valid is 17 clocks. A new start is accepted at edge k+18 at the earliest.
- start while busy=1 (including the UPDATE cycle) is ignored; the request is not queued.
- product is sampled only at acceptance; later changes have no effect.
- Zero: sign=0 even if the input was 0x0000; negative zero cannot occur.

Display scan (independent of the FSM, runs continuously):
- Divider counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances 0→1→…→5→0.
- an = ~(1 << index).
- seg decodes combinationally from the registered bcd/sign; it updates on the cycle after bcd_valid, mid-scan, with no glitch requirement beyond that.
- Digits 0..4: BCD 0..9 use standard active-low codes (0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10).
- Leading-zero blanking: digit i (1..4) shows blank (0x7F) if it and all higher digits are 0. Digit 0 is never blanked.
- Digit 5: 0x3F ("-") when sign=1, else blank 0x7F.
- Nibble values >9 cannot occur; the decoder outputs blank for them.

Test Plan:
- Reset then idle, REFRESH_DIV=4 → an cycles 111110,111101,…,011111 every 4 clocks; seg=0x40 on an[0], 0x7F on all others.
- start with product=0x3039 (12345) → busy for 17 clocks; bcd_valid pulses at edge k+17; bcd=20'h12345, sign=0.
- product=0xC000 (-16384) → bcd=20'h16384, sign=1; digit 5 seg=0x3F. Then product=0x8000 → bcd=20'h32768, sign=1.
- product=0x0007 → bcd=20'h00007; digits 1..4 and 5 blank (0x7F); digit 0 seg=0x78.
- start pulsed again at k+5 with a different product → ignored; result reflects the first product only; exactly one bcd_valid pulse.
- rst asserted at k+8 mid-conversion → bcd=0, sign=0, busy=0 immediately, no bcd_valid. After release, a new start converts correctly.
